// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator with a globally stalled valid/ready pipeline.
// Define BARREL_SHIFT_CARRY_EN to add the out_carry port and its logic.
module barrel_shift_pipe #(
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 2,
    localparam int AW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef BARREL_SHIFT_CARRY_EN
    output logic             out_carry,
`endif
    output logic [WIDTH-1:0] out_data
);

    localparam int PER = (AW + PIPE_STAGES - 1) / PIPE_STAGES;

    localparam logic [2:0] OP_ROR = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    logic             advance;
    logic             valid_q [PIPE_STAGES];
    logic             valid_d [PIPE_STAGES];
    logic [WIDTH-1:0] data_q  [PIPE_STAGES];
    logic [WIDTH-1:0] data_d  [PIPE_STAGES];
    logic [AW-1:0]    amt_q   [PIPE_STAGES];
    logic [AW-1:0]    amt_d   [PIPE_STAGES];
    logic [2:0]       op_q    [PIPE_STAGES];
    logic [2:0]       op_d    [PIPE_STAGES];
    logic             sign_q  [PIPE_STAGES];
    logic             sign_d  [PIPE_STAGES];
`ifdef BARREL_SHIFT_CARRY_EN
    logic             carry_q [PIPE_STAGES];
    logic             carry_d [PIPE_STAGES];
`endif

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[PIPE_STAGES-1];
    assign out_data  = data_q[PIPE_STAGES-1];
`ifdef BARREL_SHIFT_CARRY_EN
    assign out_carry = carry_q[PIPE_STAGES-1];
`endif

    // Level l shifts by WIDTH>>(l+1) and lives in stage l/PER.
    always_comb begin
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] xn;
        logic [AW-1:0]    a;
        logic [AW-1:0]    ta;
        logic [2:0]       op;
        logic             sg;
        int               s;
`ifdef BARREL_SHIFT_CARRY_EN
        logic [WIDTH-1:0] t;
        logic             c;
        t = '0;
        c = 1'b0;
`endif
        x  = '0;
        xn = '0;
        a  = '0;
        ta = '0;
        op = '0;
        sg = 1'b0;
        s  = 0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            if (k == 0) begin
                x  = in_data;
                a  = in_amt;
                op = in_op;
                sg = in_data[WIDTH-1];
`ifdef BARREL_SHIFT_CARRY_EN
                c  = 1'b0;
`endif
                valid_d[k] = in_valid && in_ready;
            end else begin
                x  = data_q[k-1];
                a  = amt_q[k-1];
                op = op_q[k-1];
                sg = sign_q[k-1];
`ifdef BARREL_SHIFT_CARRY_EN
                c  = carry_q[k-1];
`endif
                valid_d[k] = valid_q[k-1];
            end
            for (int l = 0; l < AW; l++) begin
                if (l / PER == k) begin
                    s  = WIDTH >> (l + 1);
                    ta = a >> (AW - 1 - l);
                    if (ta[0]) begin
                        xn = x;
                        unique case (op)
                            OP_ROR:  xn = (x >> s) | (x << (WIDTH - s));
                            OP_ROL:  xn = (x << s) | (x >> (WIDTH - s));
                            OP_SLL:  xn = x << s;
                            OP_SRL:  xn = x >> s;
                            OP_SRA:  xn = (x >> s) |
                                          (sg ? ~({WIDTH{1'b1}} >> s) : '0);
                            default: xn = x;
                        endcase
`ifdef BARREL_SHIFT_CARRY_EN
                        // The last level that moves data owns the carry.
                        unique case (op)
                            OP_ROR: c = xn[WIDTH-1];
                            OP_ROL: c = xn[0];
                            OP_SLL: begin
                                t = x >> (WIDTH - s);
                                c = t[0];
                            end
                            OP_SRL, OP_SRA: begin
                                t = x >> (s - 1);
                                c = t[0];
                            end
                            default: c = 1'b0;
                        endcase
`endif
                        x = xn;
                    end
                end
            end
            data_d[k] = x;
            amt_d[k]  = a;
            op_d[k]   = op;
            sign_d[k] = sg;
`ifdef BARREL_SHIFT_CARRY_EN
            carry_d[k] = c;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                amt_q[k]   <= '0;
                op_q[k]    <= '0;
                sign_q[k]  <= 1'b0;
`ifdef BARREL_SHIFT_CARRY_EN
                carry_q[k] <= 1'b0;
`endif
            end
        end else if (advance) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                data_q[k]  <= data_d[k];
                amt_q[k]   <= amt_d[k];
                op_q[k]    <= op_d[k];
                sign_q[k]  <= sign_d[k];
`ifdef BARREL_SHIFT_CARRY_EN
                carry_q[k] <= carry_d[k];
`endif
            end
        end
    end

endmodule
